cpu_core: RTL and testbench
===========================

Name: cpu_core

Overview:
- Instruction sequencer of the 8-bit CPU.
- Fetches 32-bit instruction words from a flat, parameterised instruction-memory bus into the instruction register.
- Generates one-hot micro-step timing (clks) for the datapath.
- Advances, jumps or halts the program counter according to control strobes returned by the decoder/datapath.

Parameters:
- RAM_SIZE, 4, number of 32-bit instruction words on the ram bus (legal range 1..256).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ram  input  RAM_SIZE*32  flat instruction memory; word k = ram[k*32 +: 32] (word 0 in bits 31:0).
- inst_condition  input  1  condition flag qualifying a jump request.
- end_inst  input  1  current instruction finished; sampled in EXEC only.
- jmp_inst  input  1  jump request; sampled with end_inst.
- hlt_inst  input  1  halt request; sampled in EXEC only.
- jmp_address  input  8  jump target word address.
- ir  output  32  instruction register.
- clks  output  16  one-hot micro-step vector (all zero outside EXEC).
- pc  output  8  program counter (word address).
- state  output  2  sequencer state: 2'b00 FETCH, 2'b01 EXEC, 2'b10 HALT.

Behaviour:
- Reset (async, any time, including mid-instruction or in HALT): pc=0, ir=0, clks=0, state=FETCH. Release is not a state change; the first rising edge after release performs FETCH.
- FETCH (1 cycle):
  - ir <= ram word[pc]; if pc >= RAM_SIZE, ir <= 32'h0000_0000.
  - clks <= 16'h0001; state <= EXEC; pc unchanged.
  - Control strobes ignored.
- EXEC, priority per rising edge:
  1. hlt_inst=1: state <= HALT; clks <= 0; pc, ir hold.
  2. end_inst=1: state <= FETCH; clks <= 0. pc <= jmp_address if (jmp_inst && inst_condition), else pc <= (pc == RAM_SIZE-1) ? 0 : pc+1.
  3. Otherwise: clks <= clks << 1, saturating at 16'h8000 (holds there; never wraps to zero).
- jmp_inst without end_inst: no effect.
- jmp_address >= RAM_SIZE: loaded unmodified; the following fetch yields ir=0.
- HALT:
  - All outputs hold; clks=0.
  - All strobes ignored.
  - Exit only via reset.
- state 2'b11 is unreachable; if ever entered, next edge goes to FETCH with clks=0.
- Instruction latency:
  - 1 FETCH cycle + N EXEC cycles, where N ≥ 1 is the cycle on which end_inst is seen.
  - Back-to-back instructions need no idle cycle.
- Outputs are registered directly; no combinational input-to-output paths.

Optional Feature:
- Macro: CPU_CORE_UNCOND_JMP_EN.
- Defined: jump taken when end_inst && jmp_inst; inst_condition ignored.
- Undefined (default): jump requires end_inst && jmp_inst && inst_condition, as in Behaviour.

Test Plan:
- RAM = {CCDDEEFF, 8899AABB, 44556677, 00112233} (word 3..0).
- Reset, release, strobes low: edge 1 -> ir=00112233, state=01, clks=0001. Edges 2-4 -> clks=0002, 0004, 0008; pc=0.
- Hold EXEC without end_inst for 20 cycles -> clks saturates at 8000, state stays 01.
- end_inst=1 continuously, jmp_inst=0 -> cycle pattern FETCH/EXEC:
  - pc=1, ir=44556677
  - pc=2, ir=8899AABB
  - pc=3, ir=CCDDEEFF
  - pc wraps to 0, ir=00112233
- end_inst=jmp_inst=inst_condition=1, jmp_address=1 -> after EXEC, pc=1; next FETCH ir=44556677.
  - Repeat with inst_condition=0 -> pc increments instead.
  - With jmp_address=9 -> ir=00000000.
- hlt_inst=1 in EXEC -> state=10, clks=0, pc/ir frozen for 10 cycles despite strobes.
  - Then assert reset for 5 ns, asynchronously mid-cycle -> immediate pc=0, ir=0, clks=0, state=00.
  - Normal fetch of 00112233 resumes.
- CPU_CORE_UNCOND_JMP_EN defined, inst_condition=0, end_inst=jmp_inst=1, jmp_address=2 -> pc=2, ir=8899AABB.

Source files
------------

// File: rtl/cpu_core.sv
// cpu_core: instruction sequencer for the 8-bit CPU.
// It fetches 32-bit words from a flat instruction bus into ir and produces a
// one-hot micro-step vector (clks) while the instruction executes. It also moves
// pc forward, jumps it, or halts it when the decoder/datapath strobes ask.
// Optional build macro: CPU_CORE_UNCOND_JMP_EN. When it is defined, a jump is
// taken on end_inst && jmp_inst and inst_condition is ignored.
module cpu_core #(
  parameter int RAM_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RAM_SIZE*32-1:0] ram,
  input  logic                  inst_condition,
  input  logic                  end_inst,
  input  logic                  jmp_inst,
  input  logic                  hlt_inst,
  input  logic [7:0]            jmp_address,
  output logic [31:0]           ir,
  output logic [15:0]           clks,
  output logic [7:0]            pc,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  localparam logic [7:0] LAST_PC = 8'(RAM_SIZE - 1);

  state_t      state_q, state_d;
  logic [31:0] ir_d, fetch_word;
  logic [15:0] clks_d;
  logic [7:0]  pc_d, pc_inc;
  logic        jmp_take;

  // Select the word at pc. Addresses past the end of memory read as zero.
  always_comb begin
    fetch_word = '0;
    for (int k = 0; k < RAM_SIZE; k++)
      if (pc == 8'(k)) fetch_word = ram[k*32 +: 32];
  end

`ifdef CPU_CORE_UNCOND_JMP_EN
  assign jmp_take = jmp_inst;
`else
  assign jmp_take = jmp_inst & inst_condition;
`endif

  // Sequential pc wraps at the last real word. A pc that was jumped out of
  // range keeps counting plainly.
  assign pc_inc = (pc == LAST_PC) ? 8'd0 : pc + 8'd1;

  // Next-state and next-output logic. Hold everything unless a state says otherwise.
  always_comb begin
    state_d = state_q;
    ir_d    = ir;
    clks_d  = clks;
    pc_d    = pc;
    case (state_q)
      ST_FETCH: begin
        ir_d    = fetch_word;
        clks_d  = 16'h0001;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (hlt_inst) begin
          state_d = ST_HALT;
          clks_d  = '0;
        end else if (end_inst) begin
          state_d = ST_FETCH;
          clks_d  = '0;
          pc_d    = jmp_take ? jmp_address : pc_inc;
        end else if (!clks[15]) begin
          // Saturate on the last micro-step instead of shifting out to zero.
          clks_d = clks << 1;
        end
      end
      ST_HALT: clks_d = '0;
      default: begin
        state_d = ST_FETCH;
        clks_d  = '0;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous and can interrupt anything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      ir      <= '0;
      clks    <= '0;
      pc      <= '0;
    end else begin
      state_q <= state_d;
      ir      <= ir_d;
      clks    <= clks_d;
      pc      <= pc_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: runs directed test-plan sequences and then randomized strobes.
// The results are compared against a step-count reference model.
module tb_cpu_core;
  localparam int RS = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [RS*32-1:0] ram;
  logic            inst_condition, end_inst, jmp_inst, hlt_inst;
  logic [7:0]      jmp_address;
  logic [31:0]     ir;
  logic [15:0]     clks;
  logic [7:0]      pc;
  logic [1:0]      state;

  cpu_core #(.RAM_SIZE(RS)) dut (
    .clk(clk), .reset(reset), .ram(ram),
    .inst_condition(inst_condition), .end_inst(end_inst),
    .jmp_inst(jmp_inst), .hlt_inst(hlt_inst), .jmp_address(jmp_address),
    .ir(ir), .clks(clks), .pc(pc), .state(state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model. m_mode: 0 = fetch due, 1 = executing, 2 = halted.
  // m_step counts the EXEC cycles already spent on the current instruction.
  logic [31:0] mem [RS];
  int          m_mode, m_step;
  logic [7:0]  m_pc;
  logic [31:0] m_ir;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] m_clks();
    if (m_mode != 1) return 16'h0;
    return 16'(1) << ((m_step > 15) ? 15 : m_step);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_step = 0; m_pc = 8'h0; m_ir = 32'h0;
  endtask

  task automatic model_edge();
    bit take;
    case (m_mode)
      0: begin
        if (int'(m_pc) < RS) m_ir = mem[int'(m_pc)];
        else m_ir = 32'h0;
        m_step = 0;
        m_mode = 1;
      end
      1: begin
        if (hlt_inst) m_mode = 2;
        else if (end_inst) begin
`ifdef CPU_CORE_UNCOND_JMP_EN
          take = jmp_inst;
`else
          take = jmp_inst && inst_condition;
`endif
          if (take) m_pc = jmp_address;
          else if (int'(m_pc) == RS - 1) m_pc = 8'h0;
          else m_pc = m_pc + 8'h1;
          m_mode = 0;
        end else m_step++;
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("ir", ir, m_ir);
    chk("clks", 32'(clks), 32'(m_clks()));
    chk("state", 32'(state), 32'(m_mode));
  endtask

  // One rising edge: advance the model with the inputs the DUT sees, then compare.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Mid-cycle asynchronous reset pulse of 5 ns, called just after an edge.
  task automatic async_reset();
    #3 reset = 1'b1;
    model_reset();
    #1 check_all();
    #4 reset = 1'b0;
  endtask

  task automatic strobes(input bit e, input bit j, input bit c, input bit h, input logic [7:0] a);
    end_inst = e; jmp_inst = j; inst_condition = c; hlt_inst = h; jmp_address = a;
  endtask

  logic [15:0] exp_step [3];
  logic [7:0]  exp_pc   [4];
  logic [31:0] exp_ir   [4];
  logic [7:0]  hold_pc;
  logic [31:0] hold_ir;

  initial begin
    exp_step = '{16'h0002, 16'h0004, 16'h0008};
    exp_pc   = '{8'd1, 8'd2, 8'd3, 8'd0};
    exp_ir   = '{32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 32'h00112233};
    ram = {32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    for (int k = 0; k < RS; k++) mem[k] = ram[k*32 +: 32];
    strobes(0, 0, 0, 0, 8'h0);
    reset = 1'b1;
    model_reset();
    #3;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_clks", 32'(clks), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    #9 reset = 1'b0;

    // First fetch, then the micro-steps walk.
    tick();
    chk("f0_ir", ir, 32'h00112233);
    chk("f0_state", 32'(state), 32'h1);
    chk("f0_clks", 32'(clks), 32'h0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("step_clks", 32'(clks), 32'(exp_step[i]));
      chk("step_pc", 32'(pc), 32'h0);
    end
    for (int i = 0; i < 20; i++) tick();
    chk("sat_clks", 32'(clks), 32'h8000);
    chk("sat_state", 32'(state), 32'h1);

    // Back-to-back sequential instructions with pc wrap.
    strobes(1, 0, 0, 0, 8'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq_pc", 32'(pc), 32'(exp_pc[i]));
      chk("seq_fetch_state", 32'(state), 32'h0);
      tick();
      chk("seq_ir", ir, exp_ir[i]);
    end

    // Conditional jump taken, then not taken, then out of range.
    strobes(1, 1, 1, 0, 8'd1);
    tick(); chk("jmp_pc", 32'(pc), 32'h1);
    tick(); chk("jmp_ir", ir, 32'h44556677);
    strobes(1, 1, 0, 0, 8'd1);
    tick();
`ifdef CPU_CORE_UNCOND_JMP_EN
    chk("nocond_pc", 32'(pc), 32'h1);
`else
    chk("nocond_pc", 32'(pc), 32'h2);
`endif
    tick();
    strobes(1, 1, 1, 0, 8'd9);
    tick(); chk("oor_pc", 32'(pc), 32'd9);
    tick(); chk("oor_ir", ir, 32'h0);
    strobes(1, 0, 0, 0, 8'd0);
    tick(); chk("oor_inc_pc", 32'(pc), 32'd10);
    tick();

    // Halt, freeze under random strobes, asynchronous reset recovery.
    strobes(0, 0, 0, 1, 8'd0);
    tick();
    chk("hlt_state", 32'(state), 32'h2);
    chk("hlt_clks", 32'(clks), 32'h0);
    hold_pc = pc; hold_ir = ir;
    for (int i = 0; i < 10; i++) begin
      strobes(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      tick();
      chk("hlt_hold_pc", 32'(pc), 32'(hold_pc));
      chk("hlt_hold_ir", ir, hold_ir);
    end
    async_reset();
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_ir", ir, 32'h0);
    chk("arst_state", 32'(state), 32'h0);
    strobes(0, 0, 0, 0, 8'd0);
    tick(); chk("resume_ir", ir, 32'h00112233);

    // Jump with the condition low: taken only in the unconditional build.
    strobes(1, 1, 0, 0, 8'd2);
    tick();
`ifdef CPU_CORE_UNCOND_JMP_EN
    chk("uncond_pc", 32'(pc), 32'h2);
`else
    chk("uncond_pc", 32'(pc), 32'h1);
`endif
    strobes(0, 0, 0, 0, 8'd0);
    tick();
`ifdef CPU_CORE_UNCOND_JMP_EN
    chk("uncond_ir", ir, 32'h8899AABB);
`else
    chk("uncond_ir", ir, 32'h44556677);
`endif

    // Randomized phase with fresh memory contents.
    for (int k = 0; k < RS; k++) begin
      mem[k] = $urandom;
      ram[k*32 +: 32] = mem[k];
    end
    for (int i = 0; i < 1500; i++) begin
      if (m_mode == 2 && $urandom_range(7) == 0) async_reset();
      strobes($urandom_range(3) == 0, 1'($urandom), 1'($urandom),
              $urandom_range(63) == 0, 8'($urandom_range(7)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
